// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver: assembles HEADER,CMD,LEN,PAYLOAD,CHK frames,
// validates them, and releases the buffered payload as a valid/ready byte stream.
module uart_rx_frame_ctrl #(
    parameter int          CLK_F         = 50_000_000,
    parameter int          BAUD          = 9600,
    parameter int          TIMEOUT_BYTES = 4,
    parameter int          MAX_LEN       = 16,
    parameter logic [7:0]  HEADER        = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic [7:0] o_cmd,
    output logic [7:0] o_len,
    output logic       o_frame_ok,
    output logic       o_err,
    output logic [2:0] o_err_code,
    output logic       o_pl_valid,
    output logic [7:0] o_pl_data,
    output logic       o_pl_last,
    input  logic       i_pl_ready,
    output logic [2:0] t_state
);

    localparam int TIMEOUT_CLKS = TIMEOUT_BYTES * 10 * (CLK_F / BAUD);
    localparam int TO_W         = $clog2(TIMEOUT_CLKS + 1);
    localparam int IDX_W        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_BAD_LEN = 3'd2;
    localparam logic [2:0] ERR_BAD_CHK = 3'd3;
    localparam logic [2:0] ERR_OVERRUN = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GET_CMD = 3'd1,
        S_GET_LEN = 3'd2,
        S_GET_PL  = 3'd3,
        S_GET_CHK = 3'd4,
        S_DELIVER = 3'd5
    } state_t;

    state_t            r_state, w_next;
    logic [TO_W-1:0]   r_to_cnt;
    logic [7:0]        r_chk, r_cmd_tmp, r_len_tmp;
    logic [IDX_W-1:0]  r_wr_idx, r_rd_idx;
    logic [7:0]        r_cmd, r_len;
    logic              r_frame_ok, r_err;
    logic [2:0]        r_err_code;
    logic              r_pl_valid, r_pl_last;
    logic [7:0]        r_pl_data;
    logic [7:0]        r_buf [MAX_LEN];

    logic              w_in_frame, w_timeout, w_wr_last, w_xfer;
    logic              w_good, w_err;
    logic [2:0]        w_err_code;
    logic [IDX_W-1:0]  w_rd_nxt;

    assign w_in_frame = (r_state == S_GET_CMD) || (r_state == S_GET_LEN) ||
                        (r_state == S_GET_PL)  || (r_state == S_GET_CHK);
    // A byte arriving on the expiry cycle keeps the frame alive.
    assign w_timeout  = w_in_frame && !i_rx_valid && (r_to_cnt == TO_LAST);
    assign w_wr_last  = (8'(r_wr_idx) == r_len_tmp - 8'd1);
    assign w_xfer     = r_pl_valid && i_pl_ready;
    assign w_rd_nxt   = r_rd_idx + 1'b1;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next     = r_state;
        w_good     = 1'b0;
        w_err      = 1'b0;
        w_err_code = 3'd0;
        case (r_state)
            S_IDLE: begin
                if (i_rx_valid && i_rx_data == HEADER) w_next = S_GET_CMD;
            end
            S_GET_CMD: begin
                if (i_rx_valid) w_next = S_GET_LEN;
            end
            S_GET_LEN: begin
                if (i_rx_valid) begin
                    if (i_rx_data > MAX_LEN_B) begin
                        w_next     = S_IDLE;
                        w_err      = 1'b1;
                        w_err_code = ERR_BAD_LEN;
                    end else if (i_rx_data == 8'd0) begin
                        w_next = S_GET_CHK;
                    end else begin
                        w_next = S_GET_PL;
                    end
                end
            end
            S_GET_PL: begin
                if (i_rx_valid && w_wr_last) w_next = S_GET_CHK;
            end
            S_GET_CHK: begin
                if (i_rx_valid) begin
                    if (i_rx_data == r_chk) begin
                        w_good = 1'b1;
                        w_next = (r_len_tmp != 8'd0) ? S_DELIVER : S_IDLE;
                    end else begin
                        w_next     = S_IDLE;
                        w_err      = 1'b1;
                        w_err_code = ERR_BAD_CHK;
                    end
                end
            end
            S_DELIVER: begin
                if (i_rx_valid) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_OVERRUN;
                end
                if (w_xfer && r_pl_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_next     = S_IDLE;
            w_err      = 1'b1;
            w_err_code = ERR_TIMEOUT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt   <= '0;
            r_chk      <= '0;
            r_cmd_tmp  <= '0;
            r_len_tmp  <= '0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_cmd      <= '0;
            r_len      <= '0;
            r_frame_ok <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= '0;
            r_pl_valid <= 1'b0;
            r_pl_data  <= '0;
            r_pl_last  <= 1'b0;
        end else begin
            r_frame_ok <= w_good;
            r_err      <= w_err;
            if (w_err) r_err_code <= w_err_code;

            if (!w_in_frame || i_rx_valid) r_to_cnt <= '0;
            else                           r_to_cnt <= r_to_cnt + 1'b1;

            if (i_rx_valid) begin
                case (r_state)
                    S_IDLE:    if (i_rx_data == HEADER) r_chk <= '0;
                    S_GET_CMD: begin
                        r_cmd_tmp <= i_rx_data;
                        r_chk     <= i_rx_data;
                    end
                    S_GET_LEN: if (i_rx_data <= MAX_LEN_B) begin
                        r_len_tmp <= i_rx_data;
                        r_chk     <= r_chk ^ i_rx_data;
                        r_wr_idx  <= '0;
                    end
                    S_GET_PL: begin
                        r_chk <= r_chk ^ i_rx_data;
                        if (!w_wr_last) r_wr_idx <= r_wr_idx + 1'b1;
                    end
                    default: ;
                endcase
            end

            if (w_good) begin
                r_cmd    <= r_cmd_tmp;
                r_len    <= r_len_tmp;
                r_rd_idx <= '0;
            end

            // First byte is staged one cycle after entering DELIVER, then advanced per transfer.
            if (r_state == S_DELIVER) begin
                if (!r_pl_valid) begin
                    r_pl_valid <= 1'b1;
                    r_pl_data  <= r_buf[r_rd_idx];
                    r_pl_last  <= (8'(r_rd_idx) == r_len - 8'd1);
                end else if (w_xfer) begin
                    if (r_pl_last) begin
                        r_pl_valid <= 1'b0;
                        r_pl_last  <= 1'b0;
                    end else begin
                        r_rd_idx  <= w_rd_nxt;
                        r_pl_data <= r_buf[w_rd_nxt];
                        r_pl_last <= (8'(w_rd_nxt) == r_len - 8'd1);
                    end
                end
            end
        end
    end

    // NOTE: the payload buffer has no reset; it is only read after being written by a verified frame.
    always_ff @(posedge clk) begin
        if (i_rx_valid && r_state == S_GET_PL) r_buf[r_wr_idx] <= i_rx_data;
    end

    assign o_cmd      = r_cmd;
    assign o_len      = r_len;
    assign o_frame_ok = r_frame_ok;
    assign o_err      = r_err;
    assign o_err_code = r_err_code;
    assign o_pl_valid = r_pl_valid;
    assign o_pl_data  = r_pl_data;
    assign o_pl_last  = r_pl_last;
    assign t_state    = r_state;

endmodule
